// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubble insertion, branch/jump
// redirect with younger-stage squash, data-memory wait freeze, and
// saturating debug counters for stall cycles and redirect events.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Rd,
    input  logic             EX_MEM_Branch,
    input  logic             EX_MEM_ALUZero,
    input  logic             EX_MEM_Jump,
    input  logic [31:0]      EX_MEM_BranchAddr,
    input  logic [31:0]      EX_MEM_JumpAddr,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_MemWrite,
    output logic             PC_Write,
    output logic             PC_Redirect,
    output logic [31:0]      PC_Target,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             MEM_WB_Flush,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushEvents
);

    localparam int unsigned WAIT_W   = 4;
    localparam bit          USE_WAIT = (MEM_LATENCY > 1);
    // Entry cycle is itself a hold cycle, so the counter starts two short.
    localparam logic [WAIT_W-1:0] WAIT_INIT =
        USE_WAIT ? WAIT_W'(MEM_LATENCY - 2) : WAIT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;

    logic redirect;
    logic mem_op;
    logic load_use;

    // Hazard conditions decoded from the current stage contents.
    assign redirect = (EX_MEM_Branch & EX_MEM_ALUZero) | EX_MEM_Jump;
    assign mem_op   = EX_MEM_MemRead | EX_MEM_MemWrite;
    assign load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                      ((ID_EX_Rd == ID_Rs) || (ID_UsesRt && (ID_EX_Rd == ID_Rt)));

    // State and wait-counter register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state logic; redirect suppresses a same-cycle wait entry.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_RUN: begin
                if (!redirect && mem_op && USE_WAIT) begin
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = WAIT_INIT;
                end
            end
            ST_MEM_WAIT: begin
                if (wait_cnt != '0) begin
                    wait_cnt_nxt = wait_cnt - WAIT_W'(1);
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Pipeline control outputs; reset and the release cycle use the normal set.
    always_comb begin
        PC_Write     = 1'b1;
        PC_Redirect  = 1'b0;
        PC_Target    = 32'd0;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        MEM_WB_Flush = 1'b0;
        if (!Rst) begin
            case (state)
                ST_RUN: begin
                    if (redirect) begin
                        PC_Redirect  = 1'b1;
                        PC_Target    = EX_MEM_Jump ? EX_MEM_JumpAddr : EX_MEM_BranchAddr;
                        IF_ID_Flush  = 1'b1;
                        ID_EX_Flush  = 1'b1;
                        EX_MEM_Flush = 1'b1;
                    end else if (mem_op && USE_WAIT) begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Write  = 1'b0;
                        EX_MEM_Write = 1'b0;
                        MEM_WB_Flush = 1'b1;
                    end else if (load_use) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (wait_cnt != '0) begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Write  = 1'b0;
                        EX_MEM_Write = 1'b0;
                        MEM_WB_Flush = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating debug counters for stalled cycles and redirects.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            StallCycles <= '0;
            FlushEvents <= '0;
        end else begin
            if (!PC_Write && (StallCycles != CNT_MAX)) begin
                StallCycles <= StallCycles + CNT_W'(1);
            end
            if (PC_Redirect && (FlushEvents != CNT_MAX)) begin
                FlushEvents <= FlushEvents + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Three instances share inputs:
// u_a (MEM_LATENCY=3), u_b (MEM_LATENCY=1), u_c (MEM_LATENCY=4, CNT_W=4).
// Control bits are packed {PC_Write, PC_Redirect, IF_ID_Write, ID_EX_Write,
// EX_MEM_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush}.
module tb_pipeline_hazard_ctrl;

    localparam logic [8:0] NORMAL  = 9'b1_0_111_0000;
    localparam logic [8:0] HOLD    = 9'b0_0_000_0001;
    localparam logic [8:0] REDIR   = 9'b1_1_111_1110;
    localparam logic [8:0] LOADUSE = 9'b0_0_011_0100;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [4:0]  ID_Rs, ID_Rt, ID_EX_Rd;
    logic        ID_UsesRt, ID_EX_MemRead;
    logic        EX_MEM_Branch, EX_MEM_ALUZero, EX_MEM_Jump;
    logic [31:0] EX_MEM_BranchAddr, EX_MEM_JumpAddr;
    logic        EX_MEM_MemRead, EX_MEM_MemWrite;

    wire [8:0]  ca, cb, cc;
    wire [31:0] tgt_a, tgt_b, tgt_c;
    wire [15:0] stall_a, flush_a, stall_b, flush_b;
    wire [3:0]  stall_c, flush_c;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    pipeline_hazard_ctrl #(.MEM_LATENCY(3), .CNT_W(16)) u_a (
        .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd),
        .EX_MEM_Branch(EX_MEM_Branch), .EX_MEM_ALUZero(EX_MEM_ALUZero),
        .EX_MEM_Jump(EX_MEM_Jump), .EX_MEM_BranchAddr(EX_MEM_BranchAddr),
        .EX_MEM_JumpAddr(EX_MEM_JumpAddr), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .PC_Write(ca[8]), .PC_Redirect(ca[7]), .PC_Target(tgt_a),
        .IF_ID_Write(ca[6]), .ID_EX_Write(ca[5]), .EX_MEM_Write(ca[4]),
        .IF_ID_Flush(ca[3]), .ID_EX_Flush(ca[2]), .EX_MEM_Flush(ca[1]),
        .MEM_WB_Flush(ca[0]), .StallCycles(stall_a), .FlushEvents(flush_a)
    );

    pipeline_hazard_ctrl #(.MEM_LATENCY(1), .CNT_W(16)) u_b (
        .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd),
        .EX_MEM_Branch(EX_MEM_Branch), .EX_MEM_ALUZero(EX_MEM_ALUZero),
        .EX_MEM_Jump(EX_MEM_Jump), .EX_MEM_BranchAddr(EX_MEM_BranchAddr),
        .EX_MEM_JumpAddr(EX_MEM_JumpAddr), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .PC_Write(cb[8]), .PC_Redirect(cb[7]), .PC_Target(tgt_b),
        .IF_ID_Write(cb[6]), .ID_EX_Write(cb[5]), .EX_MEM_Write(cb[4]),
        .IF_ID_Flush(cb[3]), .ID_EX_Flush(cb[2]), .EX_MEM_Flush(cb[1]),
        .MEM_WB_Flush(cb[0]), .StallCycles(stall_b), .FlushEvents(flush_b)
    );

    pipeline_hazard_ctrl #(.MEM_LATENCY(4), .CNT_W(4)) u_c (
        .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd),
        .EX_MEM_Branch(EX_MEM_Branch), .EX_MEM_ALUZero(EX_MEM_ALUZero),
        .EX_MEM_Jump(EX_MEM_Jump), .EX_MEM_BranchAddr(EX_MEM_BranchAddr),
        .EX_MEM_JumpAddr(EX_MEM_JumpAddr), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .PC_Write(cc[8]), .PC_Redirect(cc[7]), .PC_Target(tgt_c),
        .IF_ID_Write(cc[6]), .ID_EX_Write(cc[5]), .EX_MEM_Write(cc[4]),
        .IF_ID_Flush(cc[3]), .ID_EX_Flush(cc[2]), .EX_MEM_Flush(cc[1]),
        .MEM_WB_Flush(cc[0]), .StallCycles(stall_c), .FlushEvents(flush_c)
    );

    task automatic clear_inputs();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0;
        ID_EX_MemRead = 1'b0; ID_EX_Rd = 5'd0;
        EX_MEM_Branch = 1'b0; EX_MEM_ALUZero = 1'b0; EX_MEM_Jump = 1'b0;
        EX_MEM_BranchAddr = 32'd0; EX_MEM_JumpAddr = 32'd0;
        EX_MEM_MemRead = 1'b0; EX_MEM_MemWrite = 1'b0;
    endtask

    // One reset cycle; returns just after a falling edge with Rst released.
    task automatic do_reset();
        Rst = 1'b1;
        clear_inputs();
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd8; ID_Rs = 5'd8; ID_Rt = 5'd8; ID_UsesRt = 1'b1;
        EX_MEM_Branch = 1'b1; EX_MEM_ALUZero = 1'b1; EX_MEM_Jump = 1'b1;
        EX_MEM_BranchAddr = 32'h40; EX_MEM_JumpAddr = 32'h100;
        EX_MEM_MemRead = 1'b1; EX_MEM_MemWrite = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk); #1;
            checks++;
            if (ca !== NORMAL || cb !== NORMAL || cc !== NORMAL) begin
                errors++;
                $display("FAIL reset_ctl cyc%0d: got a=%b b=%b c=%b want %b", i, ca, cb, cc, NORMAL);
            end
            checks++;
            if (tgt_a !== 32'd0 || tgt_c !== 32'd0) begin
                errors++;
                $display("FAIL reset_tgt cyc%0d: got a=%h c=%h want 0", i, tgt_a, tgt_c);
            end
        end
        Rst = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if (stall_a !== 16'd0 || flush_a !== 16'd0 || stall_c !== 4'd0 || flush_c !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: got sa=%0d fa=%0d sc=%0d fc=%0d want 0", stall_a, flush_a, stall_c, flush_c);
        end
        // A load-use hazard right after release proves the FSM sits in RUN.
        ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd8; ID_Rs = 5'd8;
        #1;
        checks++;
        if (ca !== LOADUSE || cc !== LOADUSE) begin
            errors++;
            $display("FAIL reset_run: got a=%b c=%b want %b", ca, cc, LOADUSE);
        end
        @(negedge Clk);
    endtask

    task automatic test_load_use();
        do_reset();
        ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd8; ID_Rs = 5'd8;
        #1;
        checks++;
        if (ca !== LOADUSE) begin
            errors++;
            $display("FAIL lu_rs: got %b want %b", ca, LOADUSE);
        end
        @(negedge Clk);
        ID_EX_MemRead = 1'b0;
        #1;
        checks++;
        if (ca !== NORMAL || stall_a !== 16'd1) begin
            errors++;
            $display("FAIL lu_one_bubble: got %b stall=%0d want %b stall=1", ca, stall_a, NORMAL);
        end
        @(negedge Clk);
        ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd0; ID_Rs = 5'd0;
        #1;
        checks++;
        if (ca !== NORMAL) begin
            errors++;
            $display("FAIL lu_rd_zero: got %b want %b", ca, NORMAL);
        end
        @(negedge Clk);
        ID_EX_Rd = 5'd8; ID_Rs = 5'd3; ID_Rt = 5'd8; ID_UsesRt = 1'b0;
        #1;
        checks++;
        if (ca !== NORMAL) begin
            errors++;
            $display("FAIL lu_rt_unused: got %b want %b", ca, NORMAL);
        end
        ID_UsesRt = 1'b1;
        #1;
        checks++;
        if (ca !== LOADUSE) begin
            errors++;
            $display("FAIL lu_rt_used: got %b want %b", ca, LOADUSE);
        end
        @(negedge Clk);
    endtask

    task automatic test_branch();
        do_reset();
        EX_MEM_Branch = 1'b1; EX_MEM_ALUZero = 1'b1;
        EX_MEM_BranchAddr = 32'h40; EX_MEM_JumpAddr = 32'h100;
        EX_MEM_MemRead = 1'b1;
        #1;
        checks++;
        if (ca !== REDIR || tgt_a !== 32'h40) begin
            errors++;
            $display("FAIL br_taken: got %b tgt=%h want %b tgt=40", ca, tgt_a, REDIR);
        end
        @(negedge Clk);
        clear_inputs();
        #1;
        checks++;
        if (ca !== NORMAL || flush_a !== 16'd1 || stall_a !== 16'd0) begin
            errors++;
            $display("FAIL br_after: got %b flush=%0d stall=%0d want %b flush=1 stall=0", ca, flush_a, stall_a, NORMAL);
        end
        EX_MEM_Branch = 1'b1; EX_MEM_ALUZero = 1'b0; EX_MEM_BranchAddr = 32'h40;
        #1;
        checks++;
        if (ca !== NORMAL || tgt_a !== 32'd0) begin
            errors++;
            $display("FAIL br_not_taken: got %b tgt=%h want %b tgt=0", ca, tgt_a, NORMAL);
        end
        @(negedge Clk);
        EX_MEM_ALUZero = 1'b1; EX_MEM_Jump = 1'b1; EX_MEM_JumpAddr = 32'h100;
        #1;
        checks++;
        if (ca !== REDIR || tgt_a !== 32'h100) begin
            errors++;
            $display("FAIL jump_wins: got %b tgt=%h want %b tgt=100", ca, tgt_a, REDIR);
        end
        @(negedge Clk);
        clear_inputs();
        #1;
        checks++;
        if (flush_a !== 16'd2) begin
            errors++;
            $display("FAIL flush_count: got %0d want 2", flush_a);
        end
    endtask

    task automatic test_mem_wait();
        logic [5:0] pat;
        do_reset();
        EX_MEM_MemRead = 1'b1;
        #1;
        checks++;
        if (ca !== HOLD) begin
            errors++;
            $display("FAIL mw_hold1: got %b want %b", ca, HOLD);
        end
        @(negedge Clk); #1;
        checks++;
        if (ca !== HOLD) begin
            errors++;
            $display("FAIL mw_hold2: got %b want %b", ca, HOLD);
        end
        @(negedge Clk); #1;
        checks++;
        if (ca !== NORMAL || stall_a !== 16'd2) begin
            errors++;
            $display("FAIL mw_release: got %b stall=%0d want %b stall=2", ca, stall_a, NORMAL);
        end
        // Back-to-back loads: MemRead stays high across both operations.
        do_reset();
        pat = 6'b110110;
        EX_MEM_MemRead = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (ca !== (pat[5-i] ? HOLD : NORMAL)) begin
                errors++;
                $display("FAIL mw_b2b cyc%0d: got %b want %b", i, ca, pat[5-i] ? HOLD : NORMAL);
            end
            @(negedge Clk);
        end
        clear_inputs();
        #1;
        checks++;
        if (stall_a !== 16'd4) begin
            errors++;
            $display("FAIL mw_b2b_stall: got %0d want 4", stall_a);
        end
    endtask

    task automatic test_no_wait();
        do_reset();
        EX_MEM_MemWrite = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (cb !== NORMAL) begin
                errors++;
                $display("FAIL lat1_store cyc%0d: got %b want %b", i, cb, NORMAL);
            end
            @(negedge Clk);
        end
        #1;
        checks++;
        if (stall_b !== 16'd0) begin
            errors++;
            $display("FAIL lat1_stall: got %0d want 0", stall_b);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        EX_MEM_MemRead = 1'b1;
        @(negedge Clk); #1;
        checks++;
        if (cc !== HOLD) begin
            errors++;
            $display("FAIL rmw_hold2: got %b want %b", cc, HOLD);
        end
        Rst = 1'b1;
        #1;
        checks++;
        if (cc !== NORMAL) begin
            errors++;
            $display("FAIL rmw_in_reset: got %b want %b", cc, NORMAL);
        end
        @(negedge Clk);
        Rst = 1'b0;
        EX_MEM_MemRead = 1'b0;
        #1;
        checks++;
        if (cc !== NORMAL || stall_c !== 4'd0) begin
            errors++;
            $display("FAIL rmw_after: got %b stall=%0d want %b stall=0", cc, stall_c, NORMAL);
        end
        ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd8; ID_Rs = 5'd8;
        #1;
        checks++;
        if (cc !== LOADUSE) begin
            errors++;
            $display("FAIL rmw_run: got %b want %b", cc, LOADUSE);
        end
        @(negedge Clk);
    endtask

    task automatic test_saturation();
        do_reset();
        ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd8; ID_Rs = 5'd8;
        repeat (20) @(negedge Clk);
        #1;
        checks++;
        if (stall_c !== 4'd15) begin
            errors++;
            $display("FAIL sat_c: got %0d want 15", stall_c);
        end
        checks++;
        if (stall_a !== 16'd20) begin
            errors++;
            $display("FAIL sat_a_unsat: got %0d want 20", stall_a);
        end
        checks++;
        if (cc !== LOADUSE) begin
            errors++;
            $display("FAIL sat_ctl: got %b want %b", cc, LOADUSE);
        end
        clear_inputs();
    endtask

    initial begin
        Rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_no_wait();
        test_reset_mid_wait();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
